countdown_sequencer: RTL and testbench

Sequencing controller for the board's keypad-set countdown timer. It turns keypad events into a 4-digit BCD MM.SS setpoint and runs the 1 s tick counter. It counts the display down once per tick and drives the seven-segment blanking and the buzzer alarm when the count reaches zero. It sits between the keypad scanner, the tick counter, the seven-segment driver and the buzzer, and replaces ad-hoc glue at the top level.

---
 rtl/countdown_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_countdown_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_sequencer.sv
// Keypad-set MM.SS countdown controller: BCD setpoint entry, per-tick countdown,
// display blanking and buzzer alarm, with tick-counter clear/enable control.
module countdown_sequencer #(
    parameter int unsigned ALARM_TICKS = 5,
    parameter logic [3:0]  KEY_START   = 4'hA,
    parameter logic [3:0]  KEY_PAUSE   = 4'hB,
    parameter logic [3:0]  KEY_CLEAR   = 4'hC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  num,
    input  logic        pressed,
    input  logic        tick,
    output logic        cnt_clr,
    output logic        cnt_run,
    output logic [15:0] bcd,
    output logic        blank,
    output logic        buzz_en,
    output logic        done,
    output logic        err
);

    localparam logic [1:0] ST_ENTRY = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_ALARM = 2'd3;

    localparam int unsigned   AW         = (ALARM_TICKS < 2) ? 1 : $clog2(ALARM_TICKS + 1);
    localparam logic [AW-1:0] ALARM_LOAD = AW'(ALARM_TICKS);

    logic [1:0]    rst_sync;
    logic          sync_ok;
    logic          pressed_q;
    logic          key_ev;
    logic [3:0]    key_code;
    logic [1:0]    state;
    logic [AW-1:0] acnt;

    logic [1:0]    state_nx;
    logic [15:0]   bcd_nx;
    logic [15:0]   bcd_m1;
    logic [AW-1:0] acnt_nx;
    logic          run_nx;
    logic          blank_nx;
    logic          buzz_nx;
    logic          clr_nx;
    logic          done_nx;
    logic          err_nx;
    logic          is_digit;

    // MM.SS decrement; seconds wrap 00 -> 59 and borrow from the minutes.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [3:0] m1, m0, s1, s0;
        {m1, m0, s1, s0} = v;
        if (s0 != 4'd0) begin
            s0 = s0 - 4'd1;
        end else if (s1 != 4'd0) begin
            s1 = s1 - 4'd1;
            s0 = 4'd9;
        end else begin
            s1 = 4'd5;
            s0 = 4'd9;
            if (m0 != 4'd0) begin
                m0 = m0 - 4'd1;
            end else begin
                m0 = 4'd9;
                m1 = m1 - 4'd1;
            end
        end
        return {m1, m0, s1, s0};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign sync_ok = rst_sync[1];

    // Registers stay at their reset values until the released reset has synchronized.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pressed_q <= 1'b0;
            key_ev    <= 1'b0;
            key_code  <= '0;
        end else if (sync_ok) begin
            pressed_q <= pressed;
            key_ev    <= pressed & ~pressed_q;
            key_code  <= num;
        end
    end

    always_comb begin
        state_nx = state;
        bcd_nx   = bcd;
        acnt_nx  = acnt;
        run_nx   = cnt_run;
        blank_nx = blank;
        buzz_nx  = buzz_en;
        clr_nx   = 1'b0;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        is_digit = (key_code <= 4'd9);
        bcd_m1   = bcd_dec(bcd);

        case (state)
            ST_ENTRY: begin
                if (key_ev) begin
                    if (is_digit) begin
                        bcd_nx = {bcd[11:0], key_code};
                    end else if (key_code == KEY_CLEAR) begin
                        bcd_nx = '0;
                    end else if (key_code == KEY_START) begin
                        if (bcd == '0 || bcd[7:4] > 4'd5) begin
                            err_nx = 1'b1;
                        end else begin
                            clr_nx   = 1'b1;
                            run_nx   = 1'b1;
                            state_nx = ST_RUN;
                        end
                    end
                end
            end

            // A key event in the tick cycle wins and the tick is dropped.
            ST_RUN: begin
                if (key_ev) begin
                    if (key_code == KEY_PAUSE) begin
                        run_nx   = 1'b0;
                        state_nx = ST_PAUSE;
                    end else if (key_code == KEY_CLEAR) begin
                        bcd_nx   = '0;
                        run_nx   = 1'b0;
                        state_nx = ST_ENTRY;
                    end
                end else if (tick && bcd != '0) begin
                    bcd_nx = bcd_m1;
                    if (bcd_m1 == '0) begin
                        done_nx  = 1'b1;
                        buzz_nx  = 1'b1;
                        acnt_nx  = ALARM_LOAD;
                        state_nx = ST_ALARM;
                    end
                end
            end

            ST_PAUSE: begin
                if (key_ev) begin
                    if (key_code == KEY_PAUSE) begin
                        clr_nx   = 1'b1;
                        run_nx   = 1'b1;
                        state_nx = ST_RUN;
                    end else if (key_code == KEY_CLEAR) begin
                        bcd_nx   = '0;
                        run_nx   = 1'b0;
                        state_nx = ST_ENTRY;
                    end
                end
            end

            ST_ALARM: begin
                if (key_ev || (tick && acnt <= AW'(1))) begin
                    bcd_nx   = '0;
                    acnt_nx  = '0;
                    run_nx   = 1'b0;
                    blank_nx = 1'b0;
                    buzz_nx  = 1'b0;
                    state_nx = ST_ENTRY;
                end else if (tick) begin
                    acnt_nx  = acnt - AW'(1);
                    blank_nx = ~blank;
                end
            end

            default: begin
                state_nx = ST_ENTRY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_ENTRY;
            bcd     <= '0;
            acnt    <= '0;
            cnt_clr <= 1'b0;
            cnt_run <= 1'b0;
            blank   <= 1'b0;
            buzz_en <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else if (sync_ok) begin
            state   <= state_nx;
            bcd     <= bcd_nx;
            acnt    <= acnt_nx;
            cnt_clr <= clr_nx;
            cnt_run <= run_nx;
            blank   <= blank_nx;
            buzz_en <= buzz_nx;
            done    <= done_nx;
            err     <= err_nx;
        end
    end

endmodule

// File: tb/tb_countdown_sequencer.sv
// Bench for countdown_sequencer: seconds-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized key/tick traffic.
`timescale 1ns/1ps
module tb_countdown_sequencer;

    localparam int unsigned ALARM_TICKS = 5;
    localparam logic [3:0]  K_START = 4'hA;
    localparam logic [3:0]  K_PAUSE = 4'hB;
    localparam logic [3:0]  K_CLEAR = 4'hC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  num = 4'd0;
    logic        pressed = 1'b0;
    logic        tick = 1'b0;
    logic        cnt_clr, cnt_run, blank, buzz_en, done, err;
    logic [15:0] bcd;

    countdown_sequencer #(
        .ALARM_TICKS(ALARM_TICKS),
        .KEY_START  (K_START),
        .KEY_PAUSE  (K_PAUSE),
        .KEY_CLEAR  (K_CLEAR)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .num    (num),
        .pressed(pressed),
        .tick   (tick),
        .cnt_clr(cnt_clr),
        .cnt_run(cnt_run),
        .bcd    (bcd),
        .blank  (blank),
        .buzz_en(buzz_en),
        .done   (done),
        .err    (err)
    );

    initial forever #10 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int n_clr = 0, n_done = 0, n_err = 0;
    int hold_left = 0;
    int c0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: setpoint held as a decimal number during entry and as a
    // plain count of seconds while counting.
    typedef enum {M_ENTRY, M_RUN, M_PAUSE, M_ALARM} mode_t;
    mode_t      mode;
    int         entry, secs, alarm_left, sync_cnt;
    bit         prev_p, ev_pend;
    logic [3:0] code_pend;
    bit         e_clr, e_run, e_blank, e_buzz, e_done, e_err;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] exp_bcd();
        case (mode)
            M_ENTRY: return to_bcd(entry);
            M_ALARM: return 16'h0000;
            default: return to_bcd((secs / 60) * 100 + secs % 60);
        endcase
    endfunction

    task automatic model_reset();
        mode = M_ENTRY; entry = 0; secs = 0; alarm_left = 0; sync_cnt = 0;
        prev_p = 0; ev_pend = 0; code_pend = 4'd0;
        e_clr = 0; e_run = 0; e_blank = 0; e_buzz = 0; e_done = 0; e_err = 0;
    endtask

    task automatic go_entry();
        mode = M_ENTRY; entry = 0; e_run = 0; e_buzz = 0; e_blank = 0;
    endtask

    task automatic model_step();
        bit ev;
        logic [3:0] code;
        if (sync_cnt < 2) begin
            sync_cnt++;
            return;
        end
        ev = ev_pend;
        code = code_pend;
        ev_pend = pressed && !prev_p;
        code_pend = num;
        prev_p = pressed;
        e_clr = 0; e_done = 0; e_err = 0;
        case (mode)
            M_ENTRY: if (ev) begin
                if (code <= 4'd9) entry = (entry * 10 + int'(code)) % 10000;
                else if (code == K_CLEAR) entry = 0;
                else if (code == K_START) begin
                    if (entry == 0 || (entry / 10) % 10 > 5) e_err = 1;
                    else begin
                        secs = (entry / 100) * 60 + entry % 100;
                        e_clr = 1; e_run = 1; mode = M_RUN;
                    end
                end
            end
            M_RUN: begin
                if (ev) begin
                    if (code == K_PAUSE) begin e_run = 0; mode = M_PAUSE; end
                    else if (code == K_CLEAR) go_entry();
                end else if (tick) begin
                    secs--;
                    if (secs == 0) begin
                        e_done = 1; e_buzz = 1; alarm_left = ALARM_TICKS; mode = M_ALARM;
                    end
                end
            end
            M_PAUSE: if (ev) begin
                if (code == K_PAUSE) begin e_clr = 1; e_run = 1; mode = M_RUN; end
                else if (code == K_CLEAR) go_entry();
            end
            M_ALARM: begin
                if (ev) go_entry();
                else if (tick) begin
                    alarm_left--;
                    if (alarm_left <= 0) go_entry();
                    else e_blank = !e_blank;
                end
            end
        endcase
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial forever begin
        @(negedge clk);
        chk("outputs{clr,run,blank,buzz,done,err,bcd}",
            {cnt_clr, cnt_run, blank, buzz_en, done, err, bcd},
            {e_clr, e_run, e_blank, e_buzz, e_done, e_err, exp_bcd()});
        if (cnt_clr) n_clr++;
        if (done) n_done++;
        if (err) n_err++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] k, input int hold = 1);
        @(negedge clk);
        num = k;
        pressed = 1'b1;
        cyc(hold);
        pressed = 1'b0;
        cyc(3);
    endtask

    task automatic pulse_tick();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        cyc(1);
    endtask

    // Key event lands in the same cycle as the tick.
    task automatic press_with_tick(input logic [3:0] k);
        @(negedge clk);
        num = k;
        pressed = 1'b1;
        @(negedge clk);
        pressed = 1'b0;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        cyc(3);
    endtask

    function automatic logic [3:0] pick_key();
        int r;
        r = $urandom_range(0, 9);
        if (r < 3) return K_PAUSE;
        if (r == 3) return K_CLEAR;
        if (r == 4) return K_START;
        if (r == 5) return 4'($urandom_range(13, 15));
        return 4'($urandom_range(0, 9));
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(3);
        chk("reset_outputs", {cnt_clr, cnt_run, blank, buzz_en, done, err, bcd}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(4);

        press(4'd1); press(4'd3); press(4'd0);
        chk("entry_0130", bcd, 16'h0130);
        c0 = n_clr;
        press(K_START);
        chk("start_clr_pulses", n_clr - c0, 1);
        chk("start_run", cnt_run, 1);
        repeat (3) pulse_tick();
        chk("run_0127", bcd, 16'h0127);
        press(K_CLEAR);
        chk("clear_run", {cnt_run, bcd}, 32'h0);

        press(4'd1); press(4'd0); press(4'd0); press(K_START);
        pulse_tick();
        chk("borrow_0100_0059", bcd, 16'h0059);
        press(K_CLEAR);
        press(4'd1); press(4'd0); press(4'd0); press(4'd0); press(K_START);
        pulse_tick();
        chk("borrow_1000_0959", bcd, 16'h0959);
        press(K_CLEAR);

        c0 = n_err;
        press(K_START);
        chk("reject_0000_err", n_err - c0, 1);
        chk("reject_0000_run", cnt_run, 0);
        press(4'd7); press(4'd0); press(K_START);
        chk("reject_0070_err", n_err - c0, 2);
        chk("reject_0070_bcd", bcd, 16'h0070);
        chk("reject_0070_run", cnt_run, 0);
        press(K_CLEAR);

        press(4'd2); press(K_START);
        c0 = n_done;
        pulse_tick(); pulse_tick();
        chk("alarm_done_pulses", n_done - c0, 1);
        chk("alarm_buzz_on", buzz_en, 1);
        pulse_tick();
        chk("alarm_blank_first", blank, 1);
        repeat (3) pulse_tick();
        chk("alarm_buzz_held", buzz_en, 1);
        pulse_tick();
        chk("alarm_end", {buzz_en, blank, cnt_run, bcd}, 32'h0);

        press(4'd2); press(K_START);
        pulse_tick(); pulse_tick();
        chk("alarm2_buzz_on", buzz_en, 1);
        press(4'd5);
        chk("alarm_key_abort", {buzz_en, cnt_run, bcd}, 32'h0);

        press(4'd1); press(4'd0); press(K_START);
        press_with_tick(K_PAUSE);
        chk("pause_tick_bcd", bcd, 16'h0010);
        chk("pause_run", cnt_run, 0);
        repeat (3) pulse_tick();
        chk("pause_ignores_tick", bcd, 16'h0010);
        c0 = n_clr;
        press(K_PAUSE);
        chk("resume_clr", n_clr - c0, 1);
        chk("resume_run", cnt_run, 1);
        pulse_tick();
        chk("resume_0009", bcd, 16'h0009);

        press(K_CLEAR); press(4'd1); press(K_START);
        c0 = n_done;
        press_with_tick(K_PAUSE);
        chk("pause_beats_zero_bcd", bcd, 16'h0001);
        chk("pause_beats_zero_done", n_done - c0, 0);
        chk("pause_beats_zero_buzz", buzz_en, 0);

        press(K_CLEAR);
        press(4'd5, 1000);
        chk("long_hold_single", bcd, 16'h0005);
        press(K_START);
        pulse_tick();
        chk("run_0004", bcd, 16'h0004);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1 chk("async_reset", {cnt_clr, cnt_run, blank, buzz_en, done, err, bcd}, 32'h0);
        cyc(2);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(4);

        for (int r = 0; r < 60; r++) begin
            press(K_CLEAR);
            press(4'($urandom_range(0, 2)));
            press(4'($urandom_range(0, 9)));
            press(K_START);
            for (int c = 0; c < 150; c++) begin
                @(negedge clk);
                tick = ($urandom_range(0, 2) == 0);
                if (hold_left > 0) hold_left--;
                else if (pressed) pressed = 1'b0;
                else if ($urandom_range(0, 19) == 0) begin
                    pressed = 1'b1;
                    num = pick_key();
                    hold_left = $urandom_range(0, 3);
                end
            end
            @(negedge clk);
            pressed = 1'b0;
            tick = 1'b0;
            hold_left = 0;
        end
        cyc(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
